// File: rtl/fre_judge_pkg.sv
// fre_judge_pkg: shared state encoding and sizing helpers for the frequency/period judge.
package fre_judge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MEAN = 3'd1,
        ST_CALC = 3'd2,
        ST_ARM  = 3'd3,
        ST_MEAS = 3'd4,
        ST_DONE = 3'd5
    } state_t;

    // Wide all-ones pattern; consumers slice it down to their output width.
    localparam logic [63:0] PERIOD_MIN_INIT = {64{1'b1}};

    // Accumulator must hold 2^avg_log2 periods of out_width bits without overflow.
    function automatic int acc_width(input int out_width, input int avg_log2);
        return out_width + avg_log2;
    endfunction

endpackage

// File: rtl/fre_judge_v2_min_max_track.sv
// min_max_track: signed peak tracker over a fixed window of MA_CNT_NUM samples.
// done is a same-cycle flag meaning "the sample accepted on this edge completes the
// window", so the controller can leave MEAN exactly after the last sample.
module min_max_track
    import fre_judge_pkg::*;
#(
    parameter int INPUT_WIDTH = 16,
    parameter int CNT_WIDTH   = 32,
    parameter int MA_CNT_NUM  = 2000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clr,
    input  logic                          en,
    input  logic signed [INPUT_WIDTH-1:0] dat,
    output logic signed [INPUT_WIDTH-1:0] max,
    output logic signed [INPUT_WIDTH-1:0] min,
    output logic                          done
);

    localparam logic signed [INPUT_WIDTH-1:0] MOST_NEG = {1'b1, {(INPUT_WIDTH-1){1'b0}}};
    localparam logic signed [INPUT_WIDTH-1:0] MOST_POS = {1'b0, {(INPUT_WIDTH-1){1'b1}}};

    logic [CNT_WIDTH-1:0] cnt_r;

    assign done = en && (cnt_r == CNT_WIDTH'(MA_CNT_NUM - 1));

    // Count window samples and keep the running signed extremes
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_r <= {CNT_WIDTH{1'b0}};
            max   <= MOST_NEG;
            min   <= MOST_POS;
        end else if (en) begin
            cnt_r <= cnt_r + CNT_WIDTH'(1);
            if (dat > max) begin
                max <= dat;
            end
            if (dat < min) begin
                min <= dat;
            end
        end
    end

endmodule

// File: rtl/fre_judge_v2.sv
// fre_judge_v2: measures the peak window of a signed stream, derives a mid-level
// threshold and averages 2^AVG_LOG2 rising-edge intervals into a period estimate.
// Optional feature macro: FRE_JUDGE_HYST_EN (hysteresis around the mid level).
module fre_judge_v2
    import fre_judge_pkg::*;
#(
    parameter int INPUT_WIDTH = 16,
    parameter int OUT_WIDTH   = 18,
    parameter int CNT_WIDTH   = 32,
    parameter int MA_CNT_NUM  = 2000,
    parameter int AVG_LOG2    = 3,
    parameter int CNT_NUM     = 7200,
    parameter int MIN_PERIOD  = 100,
    parameter int HYST_SHIFT  = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic signed [INPUT_WIDTH-1:0] dat,
    input  logic                          start,
    output logic [OUT_WIDTH-1:0]          period,
    output logic [OUT_WIDTH-1:0]          period_min,
    output logic                          timeout,
    output logic                          flat,
    output logic                          busy,
    output logic                          dready
);

    localparam int ACC_W = acc_width(OUT_WIDTH, AVG_LOG2);
    localparam int XW    = INPUT_WIDTH + 1;
    localparam int NW    = AVG_LOG2 + 1;
    localparam logic [OUT_WIDTH-1:0] PMIN_INIT = PERIOD_MIN_INIT[OUT_WIDTH-1:0];
    localparam logic [NW-1:0]        N_LAST    = NW'((1 << AVG_LOG2) - 1);

    state_t                  state_r;
    logic                    q_r;
    logic signed [XW-1:0]    thr_hi_r;
    logic [OUT_WIDTH-1:0]    interval_r;
    logic [CNT_WIDTH-1:0]    tcnt_r;
    logic [ACC_W-1:0]        acc_r;
    logic [OUT_WIDTH-1:0]    pmin_r;
    logic [NW-1:0]           n_r;
    logic [OUT_WIDTH-1:0]    period_r;
    logic [OUT_WIDTH-1:0]    period_min_r;
    logic                    timeout_r;
    logic                    flat_r;
    logic                    busy_r;
    logic                    dready_r;

    logic signed [INPUT_WIDTH-1:0] trk_max_s;
    logic signed [INPUT_WIDTH-1:0] trk_min_s;
    logic                          trk_done_s;
    logic signed [XW-1:0]          max_x_s;
    logic signed [XW-1:0]          min_x_s;
    logic signed [XW-1:0]          dat_x_s;
    logic signed [XW-1:0]          mid_s;
    logic signed [XW-1:0]          thr_hi_s;
`ifdef FRE_JUDGE_HYST_EN
    logic signed [XW-1:0]          hyst_s;
    logic signed [XW-1:0]          thr_lo_s;
    logic signed [XW-1:0]          thr_lo_r;
`endif
    logic                          q_next_s;
    logic                          rise_s;
    logic                          accept_s;
    logic                          finish_s;
    logic                          tmo_s;
    logic [ACC_W-1:0]              acc_add_s;
    logic [OUT_WIDTH-1:0]          pmin_new_s;
    logic [OUT_WIDTH-1:0]          interval_inc_s;

    min_max_track #(
        .INPUT_WIDTH (INPUT_WIDTH),
        .CNT_WIDTH   (CNT_WIDTH),
        .MA_CNT_NUM  (MA_CNT_NUM)
    ) u_track (
        .clk  (clk),
        .rst  (rst),
        .clr  ((state_r == ST_IDLE) && start),
        .en   (state_r == ST_MEAN),
        .dat  (dat),
        .max  (trk_max_s),
        .min  (trk_min_s),
        .done (trk_done_s)
    );

    // Mid level and thresholds from the window extremes, one bit wider to avoid overflow
    always_comb begin
        max_x_s  = {trk_max_s[INPUT_WIDTH-1], trk_max_s};
        min_x_s  = {trk_min_s[INPUT_WIDTH-1], trk_min_s};
        dat_x_s  = {dat[INPUT_WIDTH-1], dat};
        mid_s    = (max_x_s + min_x_s) >>> 1;
`ifdef FRE_JUDGE_HYST_EN
        // max-min is never negative, so the arithmetic shift equals the logical one
        hyst_s   = (max_x_s - min_x_s) >>> HYST_SHIFT;
        thr_hi_s = mid_s + hyst_s;
        thr_lo_s = mid_s - hyst_s;
`else
        thr_hi_s = mid_s;
`endif
    end

    // Comparator, edge qualification and per-edge arithmetic
    always_comb begin
`ifdef FRE_JUDGE_HYST_EN
        if (dat_x_s > thr_hi_r) begin
            q_next_s = 1'b1;
        end else if (dat_x_s < thr_lo_r) begin
            q_next_s = 1'b0;
        end else begin
            q_next_s = q_r;
        end
`else
        q_next_s = (dat_x_s > thr_hi_r);
`endif
        rise_s         = q_next_s && !q_r;
        accept_s       = rise_s && (interval_r >= OUT_WIDTH'(MIN_PERIOD));
        finish_s       = accept_s && (n_r == N_LAST);
        tmo_s          = (tcnt_r == CNT_WIDTH'(CNT_NUM - 1));
        acc_add_s      = acc_r + ACC_W'(interval_r);
        pmin_new_s     = (interval_r < pmin_r) ? interval_r : pmin_r;
        interval_inc_s = (interval_r == {OUT_WIDTH{1'b1}}) ? interval_r
                                                          : interval_r + OUT_WIDTH'(1);
    end

    // Measurement controller with registered result outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            q_r          <= 1'b0;
            thr_hi_r     <= {XW{1'b0}};
`ifdef FRE_JUDGE_HYST_EN
            thr_lo_r     <= {XW{1'b0}};
`endif
            interval_r   <= {OUT_WIDTH{1'b0}};
            tcnt_r       <= {CNT_WIDTH{1'b0}};
            acc_r        <= {ACC_W{1'b0}};
            pmin_r       <= PMIN_INIT;
            n_r          <= {NW{1'b0}};
            period_r     <= {OUT_WIDTH{1'b0}};
            period_min_r <= PMIN_INIT;
            timeout_r    <= 1'b0;
            flat_r       <= 1'b0;
            busy_r       <= 1'b0;
            dready_r     <= 1'b0;
        end else begin
            dready_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_r    <= ST_MEAN;
                        busy_r     <= 1'b1;
                        acc_r      <= {ACC_W{1'b0}};
                        n_r        <= {NW{1'b0}};
                        pmin_r     <= PMIN_INIT;
                        interval_r <= {OUT_WIDTH{1'b0}};
                    end
                end
                ST_MEAN: begin
                    if (trk_done_s) begin
                        state_r <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    thr_hi_r <= thr_hi_s;
`ifdef FRE_JUDGE_HYST_EN
                    thr_lo_r <= thr_lo_s;
`endif
                    q_r      <= (dat_x_s > mid_s);
                    tcnt_r   <= {CNT_WIDTH{1'b0}};
                    if (trk_max_s == trk_min_s) begin
                        flat_r       <= 1'b1;
                        timeout_r    <= 1'b1;
                        period_r     <= {OUT_WIDTH{1'b0}};
                        period_min_r <= {OUT_WIDTH{1'b0}};
                        dready_r     <= 1'b1;
                        state_r      <= ST_DONE;
                    end else begin
                        state_r <= ST_ARM;
                    end
                end
                ST_ARM: begin
                    q_r    <= q_next_s;
                    tcnt_r <= tcnt_r + CNT_WIDTH'(1);
                    if (tmo_s) begin
                        timeout_r    <= 1'b1;
                        flat_r       <= 1'b0;
                        period_r     <= {OUT_WIDTH{1'b0}};
                        period_min_r <= {OUT_WIDTH{1'b0}};
                        dready_r     <= 1'b1;
                        state_r      <= ST_DONE;
                    end else if (rise_s) begin
                        interval_r <= OUT_WIDTH'(1);
                        state_r    <= ST_MEAS;
                    end
                end
                ST_MEAS: begin
                    q_r        <= q_next_s;
                    tcnt_r     <= tcnt_r + CNT_WIDTH'(1);
                    interval_r <= interval_inc_s;
                    if (accept_s) begin
                        acc_r      <= acc_add_s;
                        pmin_r     <= pmin_new_s;
                        n_r        <= n_r + NW'(1);
                        interval_r <= OUT_WIDTH'(1);
                    end
                    // The final accepted edge takes priority over a coincident timeout
                    if (finish_s) begin
                        period_r     <= acc_add_s[ACC_W-1 -: OUT_WIDTH];
                        period_min_r <= pmin_new_s;
                        timeout_r    <= 1'b0;
                        flat_r       <= 1'b0;
                        dready_r     <= 1'b1;
                        state_r      <= ST_DONE;
                    end else if (tmo_s) begin
                        timeout_r    <= 1'b1;
                        flat_r       <= 1'b0;
                        period_r     <= {OUT_WIDTH{1'b0}};
                        period_min_r <= {OUT_WIDTH{1'b0}};
                        dready_r     <= 1'b1;
                        state_r      <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign period     = period_r;
    assign period_min = period_min_r;
    assign timeout    = timeout_r;
    assign flat       = flat_r;
    assign busy       = busy_r;
    assign dready     = dready_r;

endmodule
